// File: rtl/key_bind_writer_pkg.sv
// key_bind_writer_pkg
// Shared constants, state encoding and helpers for the key-binding writer.
//   NOTE_KEY_BITS      width of one-hot note addresses and key patterns
//   KEY_BIND_DEBOUNCE  default debounce length in cycles (1 ms at 100 MHz)
//   kb_state_t         FSM encoding KB_IDLE .. KB_VERIFY
package key_bind_writer_pkg;

  localparam int NOTE_KEY_BITS     = 7;
  localparam int KEY_BIND_DEBOUNCE = 100000;

  typedef logic [NOTE_KEY_BITS-1:0] key_t;

  typedef enum logic [2:0] {
    KB_IDLE         = 3'd0,
    KB_WAIT_PRESS   = 3'd1,
    KB_WRITE        = 3'd2,
    KB_WAIT_RELEASE = 3'd3,
    KB_DONE         = 3'd4,
    KB_VERIFY       = 3'd5
  } kb_state_t;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  function automatic logic is_onehot(input key_t v);
    return (v != '0) && ((v & (v - key_t'(1))) == '0);
  endfunction

endpackage

// File: rtl/key_bind_writer_stable.sv
// key_stable_detect
// Debounce detector shared by press and release detection. A pattern is
// reported stable once it has been sampled unchanged (and qualified) for
// DEBOUNCE_CYCLES consecutive cycles. The counter saturates, never wraps.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   clr             hold the counter at zero (FSM not waiting on keys)
//   pattern [W]     current key levels
//   qualify         pattern is acceptable for the current wait
//   stable_valid    pattern held for DEBOUNCE_CYCLES cycles
//   stable_pattern  the pattern that is being tracked
module key_stable_detect
  import key_bind_writer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = KEY_BIND_DEBOUNCE,
  parameter int W               = NOTE_KEY_BITS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [W-1:0] pattern,
  input  logic         qualify,
  output logic         stable_valid,
  output logic [W-1:0] stable_pattern
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [W-1:0]     prev_q;
  logic             same;

  assign same = (pattern == prev_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      prev_q <= '0;
    end else begin
      prev_q <= pattern;
      if (clr || !qualify || !same)
        cnt_q <= '0;
      else if (cnt_q != CNT_MAX)
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // The live pattern must still match, so a change on the capture cycle
  // itself never slips through.
  assign stable_valid   = !clr && qualify && same && (cnt_q == CNT_MAX);
  assign stable_pattern = prev_q;

endmodule

// File: rtl/key_bind_writer.sv
// key_bind_writer
// Interactive note-to-key binding controller: prompts each of the NOTES
// notes in order, captures one debounced one-hot key per note and issues a
// single-cycle RAM write (ram_rw=1, ram_addr=note, ram_wdata=key).
// Optional build macro KEY_BIND_VERIFY_EN: after each write the RAM is read
// back for one cycle; one retry on mismatch, then the press is rejected.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   start         pulse, begins a session from idle
//   cancel        level, aborts a session (wins over everything)
//   keys          synchronized key levels, 1 = pressed
//   ram_rdata     RAM read data (read-back check only)
//   ram_rw        RAM write strobe
//   ram_addr      one-hot note address
//   ram_wdata     one-hot key being stored
//   prompt_note   one-hot note awaiting a key
//   busy          session active
//   done          one-cycle pulse when all notes are bound
//   err           one-cycle pulse on a rejected press
module key_bind_writer
  import key_bind_writer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = KEY_BIND_DEBOUNCE,
  parameter int NOTES           = NOTE_KEY_BITS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     cancel,
  input  logic [NOTE_KEY_BITS-1:0] keys,
  input  logic [NOTE_KEY_BITS-1:0] ram_rdata,
  output logic                     ram_rw,
  output logic [NOTE_KEY_BITS-1:0] ram_addr,
  output logic [NOTE_KEY_BITS-1:0] ram_wdata,
  output logic [NOTE_KEY_BITS-1:0] prompt_note,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int IDX_W = (NOTES > 1) ? $clog2(NOTES) : 1;

  kb_state_t  state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  key_t       used_q, used_d;
  key_t       wdata_q;
  logic       wdata_ld;
  logic       advance_q, advance_d;  // last action was a successful write
  logic       err_q, err_d;
  key_t       note_oh;
  logic       det_clr, det_qualify, det_valid;
  key_t       det_pattern;

`ifdef KEY_BIND_VERIFY_EN
  logic       retry_q, retry_d;
`else
  logic       unused_rdata;
  assign unused_rdata = ^ram_rdata;
`endif

  assign note_oh = key_t'(1) << idx_q;

  // Press wait accepts only one-hot patterns; release wait only all-zero.
  assign det_clr     = !((state_q == KB_WAIT_PRESS) || (state_q == KB_WAIT_RELEASE));
  assign det_qualify = (state_q == KB_WAIT_PRESS) ? is_onehot(keys) : (keys == '0);

  key_stable_detect #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .W               (NOTE_KEY_BITS)
  ) u_stable (
    .clk            (clk),
    .rst            (rst),
    .clr            (det_clr),
    .pattern        (keys),
    .qualify        (det_qualify),
    .stable_valid   (det_valid),
    .stable_pattern (det_pattern)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= KB_IDLE;
      idx_q     <= '0;
      used_q    <= '0;
      advance_q <= 1'b0;
      err_q     <= 1'b0;
`ifdef KEY_BIND_VERIFY_EN
      retry_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      used_q    <= used_d;
      advance_q <= advance_d;
      err_q     <= err_d;
`ifdef KEY_BIND_VERIFY_EN
      retry_q   <= retry_d;
`endif
    end
  end

  // Key to store; only observed while the FSM is writing or verifying.
  always_ff @(posedge clk) begin
    if (wdata_ld)
      wdata_q <= det_pattern;
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    used_d      = used_q;
    advance_d   = advance_q;
    err_d       = 1'b0;
    wdata_ld    = 1'b0;
`ifdef KEY_BIND_VERIFY_EN
    retry_d     = retry_q;
`endif
    ram_rw      = 1'b0;
    ram_addr    = '0;
    ram_wdata   = '0;
    prompt_note = '0;
    busy        = 1'b0;
    done        = 1'b0;

    case (state_q)
      KB_IDLE: begin
        if (start && !cancel) begin
          state_d   = KB_WAIT_PRESS;
          idx_d     = '0;
          used_d    = '0;
          advance_d = 1'b0;
        end
      end
      KB_WAIT_PRESS: begin
        busy        = 1'b1;
        prompt_note = note_oh;
        ram_addr    = note_oh;
        if (det_valid) begin
          if ((det_pattern & used_q) != '0) begin
            // Key already bound to another note: reject, re-prompt same note.
            err_d     = 1'b1;
            advance_d = 1'b0;
            state_d   = KB_WAIT_RELEASE;
          end else begin
            wdata_ld  = 1'b1;
            state_d   = KB_WRITE;
`ifdef KEY_BIND_VERIFY_EN
            retry_d   = 1'b0;
`endif
          end
        end
      end
      KB_WRITE: begin
        busy        = 1'b1;
        prompt_note = note_oh;
        ram_addr    = note_oh;
        ram_wdata   = wdata_q;
        ram_rw      = 1'b1;
        used_d      = used_q | wdata_q;
`ifdef KEY_BIND_VERIFY_EN
        state_d     = KB_VERIFY;
`else
        advance_d   = 1'b1;
        state_d     = KB_WAIT_RELEASE;
`endif
      end
`ifdef KEY_BIND_VERIFY_EN
      KB_VERIFY: begin
        busy        = 1'b1;
        prompt_note = note_oh;
        ram_addr    = note_oh;
        ram_wdata   = wdata_q;
        if (ram_rdata == wdata_q) begin
          advance_d = 1'b1;
          state_d   = KB_WAIT_RELEASE;
        end else if (!retry_q) begin
          retry_d   = 1'b1;
          state_d   = KB_WRITE;
        end else begin
          // Give up: free the key so it can be tried again.
          err_d     = 1'b1;
          used_d    = used_q & ~wdata_q;
          advance_d = 1'b0;
          state_d   = KB_WAIT_RELEASE;
        end
      end
`endif
      KB_WAIT_RELEASE: begin
        busy        = 1'b1;
        prompt_note = note_oh;
        ram_addr    = note_oh;
        if (det_valid) begin
          if (!advance_q)
            state_d = KB_WAIT_PRESS;
          else if (idx_q == IDX_W'(NOTES - 1))
            state_d = KB_DONE;
          else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = KB_WAIT_PRESS;
          end
        end
      end
      KB_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = KB_IDLE;
      end
      default: state_d = KB_IDLE;
    endcase

    // Abort overrides every transition and suppresses a pending write strobe.
    if (cancel && (state_q != KB_IDLE)) begin
      state_d = KB_IDLE;
      ram_rw  = 1'b0;
      done    = 1'b0;
      err_d   = 1'b0;
    end
  end

  assign err = err_q;

endmodule
